clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the period and high time of a slow, asynchronous periodic input in cycles of the 50 MHz board clock. It pairs with the board clock divider: it verifies divider outputs, and it characterises external slow clocks or tick inputs against the system clock. Results appear as registered values with a one-cycle valid strobe. A stall flag marks an input that has stopped toggling.

## Interface
- WIDTH, 25, width of the cycle counter and result registers
- TIMEOUT, 25_000_000, clk cycles without a qualifying event before the stall flag is raised; legal range 4 ≤ TIMEOUT ≤ 2^WIDTH−1
- clk  input  1  board clock, 50 MHz, all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- sig_in  input  1  measured signal, asynchronous to clk
- period  output  WIDTH  clk cycles between the last two synchronized rising edges
- high_time  output  WIDTH  clk cycles sig was high within that period
- valid  output  1  one-cycle pulse when period/high_time update
- stalled  output  1  level, no edge within TIMEOUT cycles

## Operation
- Synchronizer: a two-flop chain s1→s2, plus a history flop s3.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
  - All three flops reset to 0.
- Counter cnt, WIDTH bits, resets to 0, increments every cycle unless cleared.
  - It cannot overflow because TIMEOUT bounds it.
- States: ARM, WAIT_FIRST, MEASURE. Reset state is ARM.
- ARM waits for a synchronized low level, so an input that is already high at reset is not taken as a rising edge.
  - If s2==0: go to WAIT_FIRST, cnt←0.
- WAIT_FIRST: on rise, go to MEASURE, cnt←0, hi_cap←0.
  - No valid is issued; the first edge is a reference only.
- MEASURE:
  - On fall: hi_cap←cnt+1.
  - On rise:
    - period←cnt+1.
    - high_time←hi_cap.
    - valid←1.
    - stalled←0.
    - cnt←0.
    - Stay in MEASURE.
  - If rise and fall occur in the same cycle, that is impossible after synchronization; no special handling.
- Timeout, in every state: if the state's qualifying event is absent and cnt==TIMEOUT−1:
  - stalled←1.
  - state←ARM.
  - cnt←0.
  - period and high_time hold their last values.
  - No valid is issued.
  - Qualifying events: ARM: s2==0. WAIT_FIRST: rise. MEASURE: rise.
- A qualifying event in the same cycle as the timeout wins, and no stall is raised.
- Fall in ARM or WAIT_FIRST is ignored.
- Reset mid-measurement:
  - All state is discarded.
  - Outputs return to reset values immediately (asynchronous reset).
  - The next valid requires an ARM → first rise → second rise sequence.

## Timing
- Reset values: period=0, high_time=0, valid=0, stalled=0.
- Synchronizer latency: a sig_in edge meeting setup before clk edge k gives rise/fall true in the cycle after edge k+1.
- Result latency: valid, period and high_time are registered. They change on the clk edge that ends the cycle in which the second rise is detected, 3 clk edges after the sig_in rising edge.
- period equals the input period P in clk cycles exactly, for any P ≥ 2 with each level held ≥ 1 cycle.
- high_time equals the high duration H exactly.
- valid is high for exactly one cycle per measured period.
- Consecutive valid pulses are P cycles apart.
- stalled asserts TIMEOUT cycles after the last qualifying event. It remains high until the next valid.

## Test plan
- Reset behaviour: hold rst_n=0 with sig_in toggling → all outputs 0. Release with sig_in=1 → no valid until a full low→high→low→high sequence has occurred.
- Steady clock: sig_in with period 50 and high 20 → the first valid comes at the second rising edge, with period=50 and high_time=20. Subsequent valid pulses are 50 cycles apart with the same values.
- Minimum period: sig_in toggling every clk cycle (P=2, H=1) → period=2, high_time=1, valid every 2 cycles.
- Divider pairing: feed a 100-cycle square wave (50 high) → period=100, high_time=50.
- Stall: bench TIMEOUT=200, run P=50, then hold sig_in low → stalled=1 exactly 200 cycles after the last detected rise. period stays 50, and valid stays 0. Restart P=30 → the first valid after two rises gives period=30, and stalled drops on the same edge.
- Mid-run reset: assert rst_n=0 for 3 cycles between rising edges → outputs 0 at once. After release, the first valid appears only after ARM plus two rises, carrying the correct period.

Source files
------------

// File: rtl/clk_period_meter_if.sv
// Result bundle of the clock period meter: measured input plus registered results.
// The meter drives the results (master); the consumer drives the measured signal (slave).
interface clk_period_meter_if #(
    parameter int unsigned WIDTH = 25
);
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             stalled;

    modport master (
        input  sig_in,
        output period,
        output high_time,
        output valid,
        output stalled
    );

    modport slave (
        output sig_in,
        input  period,
        input  high_time,
        input  valid,
        input  stalled
    );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk cycles,
// with a one-cycle valid strobe and a stall flag for an input that stops toggling.
module clk_period_meter #(
    parameter int unsigned WIDTH   = 25,
    parameter int unsigned TIMEOUT = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    clk_period_meter_if.master bus
);

    typedef enum logic [1:0] {StArm, StWaitFirst, StMeasure} state_e;

    localparam logic [WIDTH-1:0] TimeoutLast = WIDTH'(TIMEOUT - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [1:0]       r_fill;
    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_d;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] r_hi_cap;
    logic [WIDTH-1:0] w_hi_cap_d;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] w_period_d;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] w_high_d;
    logic             r_valid;
    logic             w_valid_d;
    logic             r_stalled;
    logic             w_stalled_d;
    logic             w_rise;
    logic             w_fall;
    logic             w_primed;
    logic             w_event;

    // r_fill marks when s2 holds a real sample; the reset zeros in the chain
    // must not count as a low level, or a high input at reset would look like a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_fill <= 2'b00;
        end else begin
            r_s1   <= bus.sig_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_fill <= {r_fill[0], 1'b1};
        end
    end

    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    assign w_primed  = r_fill[1];
    assign w_cnt_inc = r_cnt + WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StArm;
            r_cnt     <= '0;
            r_hi_cap  <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_hi_cap  <= w_hi_cap_d;
            r_period  <= w_period_d;
            r_high    <= w_high_d;
            r_valid   <= w_valid_d;
            r_stalled <= w_stalled_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = w_cnt_inc;
        w_hi_cap_d  = r_hi_cap;
        w_period_d  = r_period;
        w_high_d    = r_high;
        w_valid_d   = 1'b0;
        w_stalled_d = r_stalled;
        w_event     = 1'b0;

        unique case (r_state)
            StArm: begin
                w_event = w_primed & ~r_s2;
                if (w_event) begin
                    w_state_d = StWaitFirst;
                    w_cnt_d   = '0;
                end
            end
            StWaitFirst: begin
                w_event = w_rise;
                if (w_event) begin
                    w_state_d  = StMeasure;
                    w_cnt_d    = '0;
                    w_hi_cap_d = '0;
                end
            end
            StMeasure: begin
                w_event = w_rise;
                if (w_rise) begin
                    w_period_d  = w_cnt_inc;
                    w_high_d    = r_hi_cap;
                    w_valid_d   = 1'b1;
                    w_stalled_d = 1'b0;
                    w_cnt_d     = '0;
                end else if (w_fall) begin
                    w_hi_cap_d = w_cnt_inc;
                end
            end
            default: begin
                w_state_d = StArm;
                w_cnt_d   = '0;
            end
        endcase

        // A qualifying event in the timeout cycle wins over the stall.
        if (!w_event && (r_cnt == TimeoutLast)) begin
            w_stalled_d = 1'b1;
            w_state_d   = StArm;
            w_cnt_d     = '0;
        end
    end

    assign bus.period    = r_period;
    assign bus.high_time = r_high;
    assign bus.valid     = r_valid;
    assign bus.stalled   = r_stalled;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: stimulus pushes expected results derived
// from input edge times; a negedge monitor pops and compares on valid and stall.
module tb_clk_period_meter;

    localparam int unsigned WIDTH = 25;
    localparam int unsigned T     = 200;

    typedef struct packed {
        int t;
        int per;
        int hi;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_period_meter_if #(.WIDTH(WIDTH)) bus ();

    clk_period_meter #(
        .WIDTH  (WIDTH),
        .TIMEOUT(T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t vq[$];
    int   sq[$];
    int   sq_per[$];

    // Reference model state: edge times of the driven input, in clk cycles.
    bit   have_ref = 1'b0;
    bit   mstalled = 1'b0;
    bit   in_reset = 1'b1;
    logic sig_cur  = 1'b0;
    int   last_rise = 0;
    int   last_fall = 0;
    int   last_per  = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endfunction

    // A rise after a reference rise completes one period; result visible 3 edges later.
    function automatic void model_rise(input int n);
        if (have_ref) begin
            vq.push_back('{t: n + 3, per: n - last_rise, hi: last_fall - last_rise});
            last_per = n - last_rise;
            mstalled = 1'b0;
        end
        have_ref  = 1'b1;
        last_rise = n;
    endfunction

    // No rise within T cycles of the last one: stall, and the next rise is a reference.
    function automatic void stall_check();
        if (!in_reset && have_ref && (cyc - last_rise == T)) begin
            if (!mstalled) begin
                sq.push_back(last_rise + 3 + T);
                sq_per.push_back(last_per);
            end
            mstalled = 1'b1;
            have_ref = 1'b0;
        end
    endfunction

    task automatic step(input logic lvl);
        @(posedge clk);
        #1;
        if (lvl != sig_cur) begin
            if (!in_reset) begin
                if (lvl) model_rise(cyc);
                else last_fall = cyc;
            end
            bus.sig_in = lvl;
            sig_cur    = lvl;
        end
        stall_check();
    endtask

    task automatic drive(input logic lvl, input int len);
        for (int i = 0; i < len; i++) step(lvl);
    endtask

    task automatic periods(input int p, input int h, input int k);
        for (int i = 0; i < k; i++) begin
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_period"}, int'(bus.period), 0);
        chk({tag, "_high"}, int'(bus.high_time), 0);
        chk({tag, "_valid"}, int'(bus.valid), 0);
        chk({tag, "_stalled"}, int'(bus.stalled), 0);
    endtask

    task automatic do_reset(input int cycles, input bit toggle, input logic rel_lvl);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_reset = 1'b1;
        have_ref = 1'b0;
        mstalled = 1'b0;
        last_per = 0;
        #1;
        check_zero("rst_now");
        for (int i = 0; i < cycles; i++) step(toggle ? ~sig_cur : sig_cur);
        step(rel_lvl);
        #1;
        check_zero("rst_hold");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_reset = 1'b0;
        drive(rel_lvl, 6);
    endtask

    logic prev_st = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_st = 1'b0;
        end else begin
            while (vq.size() > 0 && vq[0].t < cyc) begin
                chk("valid_missed", cyc, vq[0].t);
                void'(vq.pop_front());
            end
            while (sq.size() > 0 && sq[0] < cyc) begin
                chk("stall_missed", cyc, sq[0]);
                void'(sq.pop_front());
                void'(sq_per.pop_front());
            end
            if (bus.valid) begin
                chk("valid_expected", int'(vq.size() > 0), 1);
                if (vq.size() > 0) begin
                    e = vq.pop_front();
                    chk("valid_time", cyc, e.t);
                    chk("period", int'(bus.period), e.per);
                    chk("high_time", int'(bus.high_time), e.hi);
                    chk("stall_clear", int'(bus.stalled), 0);
                end
            end
            if (bus.stalled && !prev_st) begin
                chk("stall_expected", int'(sq.size() > 0), 1);
                if (sq.size() > 0) begin
                    chk("stall_time", cyc, sq.pop_front());
                    chk("held_period", int'(bus.period), sq_per.pop_front());
                end
            end
            if (!bus.stalled && prev_st) chk("stall_hold", int'(bus.valid), 1);
            prev_st = bus.stalled;
        end
    end

    initial begin
        int p;
        int h;
        int k;
        bus.sig_in = 1'b0;

        // Toggle during reset, release with the input high.
        do_reset(6, 1'b1, 1'b1);

        periods(50, 20, 6);
        periods(2, 1, 8);
        periods(100, 50, 4);

        for (int b = 0; b < 10; b++) begin
            p = int'($urandom_range(120, 2));
            h = int'($urandom_range(p - 1, 1));
            k = int'($urandom_range(5, 3));
            periods(p, h, k);
        end

        // Period equal to the timeout still measures.
        periods(T, int'($urandom_range(T - 1, 1)), 3);

        // Stall after P=50, then restart at P=30.
        periods(50, 20, 3);
        drive(1'b1, 20);
        drive(1'b0, T + 30);
        periods(30, 15, 4);

        // Reset between rising edges, then resume.
        periods(50, 20, 3);
        drive(1'b1, 20);
        drive(1'b0, 10);
        do_reset(3, 1'b0, 1'b0);
        periods(40, 10, 4);

        drive(1'b0, 12);
        chk("queue_drained", vq.size() + sq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
